// File: rtl/final_adder_arbiter.sv
// final_adder_arbiter: round-robin scheduler that shares one 24-bit final adder
// between two Dadda reduction trees. A granted sum/carry pair is held in an
// operand stage (S1) that drives the adder. The 22-bit result and the requester
// tag are captured in a result stage (S2) that honours downstream backpressure.
module final_adder_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [23:0]      req0_a,
    input  logic [23:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [23:0]      req1_a,
    input  logic [23:0]      req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [21:0]      res_sum,
    output logic             res_id,
    output logic [CNT_W-1:0] done_cnt
);

    // Operand stage (S1)
    logic             op_valid_r;
    logic [23:0]      op_a_r;
    logic [23:0]      op_b_r;
    logic             op_id_r;
    // Round-robin pointer: 0 favours requester 0
    logic             prio_r;
    // Result stage (S2)
    logic             res_valid_r;
    logic [21:0]      res_sum_r;
    logic             res_id_r;
    logic [CNT_W-1:0] done_cnt_r;

    logic             s2_load_s;
    logic             s1_free_s;
    logic             rdy0_s;
    logic             rdy1_s;
    logic             hs0_s;
    logic             hs1_s;
    logic [23:0]      add_s;

    // Pipeline advance conditions, arbitration and the shared adder
    always_comb begin
        s2_load_s = op_valid_r && (!res_valid_r || res_ready);
        s1_free_s = !op_valid_r || s2_load_s;
        // A ready never looks at its own valid; it only yields to the
        // favoured requester when that requester is actually asking.
        rdy0_s    = !rst && s1_free_s && !(req1_valid && (prio_r == 1'b1));
        rdy1_s    = !rst && s1_free_s && !(req0_valid && (prio_r == 1'b0));
        hs0_s     = req0_valid && rdy0_s;
        hs1_s     = req1_valid && rdy1_s;
        // Carry-out and bits 23:22 are dropped when the result is stored.
        add_s     = op_a_r + op_b_r;
    end

    assign req0_ready = rdy0_s;
    assign req1_ready = rdy1_s;
    assign res_valid  = res_valid_r;
    assign res_sum    = res_sum_r;
    assign res_id     = res_id_r;
    assign done_cnt   = done_cnt_r;

    // S1 operand register and priority pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid_r <= 1'b0;
            op_a_r     <= 24'd0;
            op_b_r     <= 24'd0;
            op_id_r    <= 1'b0;
            prio_r     <= 1'b0;
        end else if (hs0_s) begin
            op_valid_r <= 1'b1;
            op_a_r     <= req0_a;
            op_b_r     <= req0_b;
            op_id_r    <= 1'b0;
            prio_r     <= 1'b1;
        end else if (hs1_s) begin
            op_valid_r <= 1'b1;
            op_a_r     <= req1_a;
            op_b_r     <= req1_b;
            op_id_r    <= 1'b1;
            prio_r     <= 1'b0;
        end else if (s2_load_s) begin
            op_valid_r <= 1'b0;
        end else begin
            op_valid_r <= op_valid_r;
        end
    end

    // S2 result register: load from the adder, or empty when drained
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_sum_r   <= 22'd0;
            res_id_r    <= 1'b0;
        end else if (s2_load_s) begin
            res_valid_r <= 1'b1;
            res_sum_r   <= add_s[21:0];
            res_id_r    <= op_id_r;
        end else if (res_valid_r && res_ready) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    // Count results taken downstream; wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_r <= {CNT_W{1'b0}};
        end else if (res_valid_r && res_ready) begin
            done_cnt_r <= done_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            done_cnt_r <= done_cnt_r;
        end
    end

endmodule
